fp_sort_sequencer: RTL and testbench

- Sequenced N-entry floating-point sorter built around one shared instance of the existing combinational fp_sorter compare/swap unit.
- Accepts a burst of N float_pkg::float values on a valid/ready input stream and buffers them internally.
- Runs a fixed-schedule bubble sort, performing one compare/swap per cycle through fp_sorter.
- Streams the result out in descending order (largest first) on a valid/ready output stream.

---
 rtl/fp_sort_sequencer.sv | 132 +++++++++++++
 tb/tb_fp_sort_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sort_sequencer.sv
// Sequenced N-entry float sorter: load a burst, bubble-sort it through one shared
// fp_sorter compare/swap unit, then stream the result out largest first.

package float_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;
endpackage

// Combinational compare/swap on IEEE-754 singles using a sign-magnitude to
// unsigned key mapping, so -0 orders below +0 and positive NaNs sort highest.
module fp_sorter (
  input  float_pkg::float a,
  input  float_pkg::float b,
  output float_pkg::float bign,
  output float_pkg::float smalln
);
  logic [31:0] raw_a, raw_b, key_a, key_b;

  assign raw_a = a;
  assign raw_b = b;

  always_comb begin
    key_a = a.sign ? ~raw_a : (raw_a | 32'h8000_0000);
    key_b = b.sign ? ~raw_b : (raw_b | 32'h8000_0000);
    if (key_a >= key_b) begin
      bign   = a;
      smalln = b;
    end else begin
      bign   = b;
      smalln = a;
    end
  end
endmodule

module fp_sort_sequencer #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  float_pkg::float in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output float_pkg::float out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);
  typedef enum logic [1:0] {LOAD, SORT, OUTPUT} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [IDXW-1:0] LAST_CMP = IDXW'(N - 2);

  state_t          state;
  float_pkg::float mem [N];
  logic [IDXW-1:0] wr_idx, rd_idx, cmp_idx, pass, cmp_nxt;
  float_pkg::float bign, smalln;

  assign cmp_nxt  = cmp_idx + IDXW'(1);
  assign out_data = mem[rd_idx];

  fp_sorter u_sorter (
    .a      (mem[cmp_idx]),
    .b      (mem[cmp_nxt]),
    .bign   (bign),
    .smalln (smalln)
  );

  // Fixed (N-1) passes of N-1 compares each; no early exit so latency is constant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      cmp_idx   <= '0;
      pass      <= '0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            mem[wr_idx] <= in_data;
            if (wr_idx == LAST_IDX) begin
              wr_idx   <= '0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              wr_idx <= wr_idx + IDXW'(1);
            end
          end
        end
        SORT: begin
          mem[cmp_idx] <= bign;
          mem[cmp_nxt] <= smalln;
          if (cmp_idx == LAST_CMP) begin
            cmp_idx <= '0;
            if (pass == LAST_CMP) begin
              pass      <= '0;
              state     <= OUTPUT;
              busy      <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              pass <= pass + IDXW'(1);
            end
          end else begin
            cmp_idx <= cmp_nxt;
          end
        end
        OUTPUT: begin
          if (out_valid && out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx    <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IDXW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_sort_sequencer.sv
// Scoreboard bench for fp_sort_sequencer: expected sorted streams are queued at
// load time and a negedge monitor pops/compares every output transfer.

module tb_fp_sort_sequencer;
  logic            clk = 1'b0;
  logic            reset;
  float_pkg::float in_data;
  logic            in_valid;
  logic            in_ready;
  float_pkg::float out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  fp_sort_sequencer #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] job_in  [8];
  logic [31:0] job_exp [8];
  int          last_acc_cyc, first_out_cyc, last_xfer_cyc;
  int          busy_cnt, xfer_cnt, load_len;
  bit          seen_out, stall_prev;
  logic [31:0] held_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares transfers against the scoreboard and checks hold under backpressure
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (out_valid) begin
        if (!seen_out) begin
          seen_out      = 1'b1;
          first_out_cyc = cyc;
        end
        if (stall_prev) check_output("hold_stable", out_data, held_data);
        if (out_ready) begin
          check_output("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check_output("out_data", out_data, exp_q.pop_front());
          xfer_cnt++;
          last_xfer_cyc = cyc;
          stall_prev    = 1'b0;
        end else begin
          stall_prev = 1'b1;
          held_data  = out_data;
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic load_job(input bit gapped);
    int waits;
    int start_cyc;
    start_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (gapped) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = job_in[i];
      waits    = 0;
      while (!in_ready && waits < 200) begin
        @(posedge clk); #1;
        waits++;
      end
      if (waits >= 200) check_output("load_timeout", 32'(waits), 32'd0);
      last_acc_cyc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    load_len = last_acc_cyc - start_cyc + 1;
  endtask

  task automatic apply_stimulus(input bit gapped, input bit bp, input bit hold_valid);
    int waits;
    int k;
    seen_out = 1'b0;
    busy_cnt = 0;
    xfer_cnt = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back(job_exp[i]);
    load_job(gapped);
    check_output("load_len", 32'(load_len), gapped ? 32'd16 : 32'd8);
    if (hold_valid) begin
      in_valid = 1'b1;
      in_data  = 32'h7F00_0000;
    end
    check_output("in_ready_after_load", 32'(in_ready), 32'd0);
    check_output("busy_after_load", 32'(busy), 32'd1);
    waits = 0;
    k = 0;
    while (!in_ready && waits < 400) begin
      out_ready = bp ? (k % 3 == 0) : 1'b1;
      if (out_valid) k++;
      @(posedge clk); #1;
      waits++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output("drain_in_time", 32'(waits < 400), 32'd1);
    check_output("in_ready_after_last", 32'(cyc - last_xfer_cyc), 32'd1);
    check_output("xfer_count", 32'(xfer_cnt), 32'd8);
    check_output("busy_cycles", 32'(busy_cnt), 32'd49);
    check_output("latency", 32'(first_out_cyc - last_acc_cyc), 32'd50);
    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check_output("out_valid_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_out_data", out_data, 32'h0);

    $display("[TB] ascending 1..8, in_valid held high through sort/output");
    job_in  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    job_exp = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    apply_stimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] mixed signs, back-to-back with previous job");
    job_in  = '{32'h40600000, 32'h40E66666, 32'hC0800000, 32'hC0A00000,
                32'h40400000, 32'h00000000, 32'hBF000000, 32'h42C80000};
    job_exp = '{32'h42C80000, 32'h40E66666, 32'h40600000, 32'h40400000,
                32'h00000000, 32'hBF000000, 32'hC0800000, 32'hC0A00000};
    apply_stimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] duplicates with gapped loading");
    job_in  = '{32'h40000000, 32'hBF800000, 32'h40000000, 32'hBF800000,
                32'h40A00000, 32'h40A00000, 32'h3E800000, 32'h3E800000};
    job_exp = '{32'h40A00000, 32'h40A00000, 32'h40000000, 32'h40000000,
                32'h3E800000, 32'h3E800000, 32'hBF800000, 32'hBF800000};
    apply_stimulus(1'b1, 1'b0, 1'b0);

    $display("[TB] output backpressure 1,0,0 pattern");
    job_in  = '{32'h40C00000, 32'h3F800000, 32'h41000000, 32'h40400000,
                32'h40A00000, 32'h40000000, 32'h40E00000, 32'h40800000};
    job_exp = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    apply_stimulus(1'b0, 1'b1, 1'b0);

    $display("[TB] reset in the middle of sort");
    job_in  = '{32'h42C80000, 32'h42C80000, 32'h42C80000, 32'h42C80000,
                32'hC2C80000, 32'hC2C80000, 32'hC2C80000, 32'hC2C80000};
    load_job(1'b0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    check_output("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("midrst_in_ready", 32'(in_ready), 32'd1);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_out_valid", 32'(out_valid), 32'd0);
    check_output("midrst_out_data", out_data, 32'h0);

    job_in  = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    job_exp = '{32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000,
                32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    apply_stimulus(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
